// File: rtl/cnt_rr_sched.sv
// cnt_rr_sched -- round-robin front end for one shared 74193-style nibble counter.
// Each requester posts a read/inc/dec/load command through a valid/ready
// handshake. The block issues one single-cycle strobe to the counter, then
// returns the post-op count together with a wrap (or saturation) flag.
// Optional feature: define CNT_RR_SCHED_SAT_EN to make the counter saturate.
// When it is defined, an inc at the maximum count or a dec at zero is dropped
// and rsp_wrap reports the saturation hit.
module cnt_rr_sched #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 4,
   parameter int START_DLY = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [2*NUM_REQ-1:0]         req_op,
   input  logic [WIDTH*NUM_REQ-1:0]     req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         cnt_load_en,
   output logic                         cnt_inc_en,
   output logic                         cnt_dec_en,
   output logic [WIDTH-1:0]             cnt_din,
   input  logic [WIDTH-1:0]             cnt_dout,
   output logic                         rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]             rsp_data,
   output logic                         rsp_wrap,
   output logic                         busy
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_MIN = '0;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_READ = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_LOAD = 2'b11
   } op_t;

   state_t                state;
   state_t                state_next;
   logic [START_DLY-1:0]  start_sr;
   logic [START_DLY-1:0]  start_sr_shift;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       rr_ptr_next;
   logic [ID_W-1:0]       grant_id;
   op_t                   grant_op;
   logic [WIDTH-1:0]      pre_cnt;

   logic                  arb_found;
   logic [ID_W-1:0]       arb_id;
   op_t                   arb_op;
   logic [ID_W:0]         arb_sum;
   logic [NUM_REQ-1:0]    rot_valid;

   logic                  grant_valid;
   logic [WIDTH-1:0]      grant_data;
   logic                  at_max;
   logic                  at_min;
   logic                  sat_block;
   logic                  wrap_flag;

   // Start-up enable: ones shift in while in START, the last stage opens IDLE.
   assign start_sr_shift = {start_sr[START_DLY-1:0], 1'b1} >> 1 | (start_sr << 1) | START_DLY'(1);

   // Rotate the valid vector so bit 0 is the requester that rr_ptr points at.
   assign rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

   // Pointer after serving grant_id, wrapping at NUM_REQ (which need not be a power of two).
   assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // Pre-op boundary detection on the count captured when the strobe went out.
   assign at_max    = (pre_cnt == CNT_MAX);
   assign at_min    = (pre_cnt == CNT_MIN);
   assign wrap_flag = ((grant_op == OP_INC) && at_max) || ((grant_op == OP_DEC) && at_min);

   // Saturation suppression looks at the live count during ISSUE, before the strobe fires.
`ifdef CNT_RR_SCHED_SAT_EN
   assign sat_block = ((grant_op == OP_INC) && (cnt_dout == CNT_MAX)) ||
                      ((grant_op == OP_DEC) && (cnt_dout == CNT_MIN));
`else
   assign sat_block = 1'b0;
`endif

   // Round-robin search: first valid requester at or after rr_ptr, plus its op.
   always_comb begin
      arb_found = 1'b0;
      arb_id    = '0;
      arb_sum   = '0;
      arb_op    = OP_READ;
      for (int off = 0; off < NUM_REQ; off++) begin
         if (!arb_found && rot_valid[off]) begin
            arb_found = 1'b1;
            arb_sum   = {1'b0, rr_ptr} + (ID_W+1)'(off);
            if (arb_sum >= (ID_W+1)'(NUM_REQ)) begin
               arb_sum = arb_sum - (ID_W+1)'(NUM_REQ);
            end
            arb_id = arb_sum[ID_W-1:0];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_id == ID_W'(i)) begin
            arb_op = op_t'(req_op[2*i +: 2]);
         end
      end
   end

   // Live valid and load value of the granted requester; a dropped valid cancels the issue.
   always_comb begin
      grant_valid = 1'b0;
      grant_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            grant_valid = req_valid[i];
            grant_data  = req_data[WIDTH*i +: WIDTH];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_START;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_START: begin
            if (start_sr_shift[START_DLY-1]) begin
               state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (arb_found) begin
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (grant_valid) begin
               state_next = ST_RESP;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_START;
         end
      endcase
   end

   // FSM outputs: counter strobes and ready in ISSUE, response fields in RESP.
   always_comb begin
      req_ready   = '0;
      cnt_load_en = 1'b0;
      cnt_inc_en  = 1'b0;
      cnt_dec_en  = 1'b0;
      cnt_din     = '0;
      rsp_valid   = 1'b0;
      rsp_id      = '0;
      rsp_data    = '0;
      rsp_wrap    = 1'b0;
      busy        = (state != ST_IDLE);
      case (state)
         ST_ISSUE: begin
            if (grant_valid) begin
               req_ready = NUM_REQ'(1) << grant_id;
               case (grant_op)
                  OP_INC:  cnt_inc_en = !sat_block;
                  OP_DEC:  cnt_dec_en = !sat_block;
                  OP_LOAD: begin
                     cnt_load_en = 1'b1;
                     cnt_din     = grant_data;
                  end
                  default: begin
                     cnt_load_en = 1'b0;
                  end
               endcase
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_id    = grant_id;
            rsp_data  = cnt_dout;
            rsp_wrap  = wrap_flag;
         end
         default: begin
            rsp_valid = 1'b0;
         end
      endcase
   end

   // Datapath registers: start-up delay, grant capture, pre-op count and round-robin pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_sr <= '0;
         rr_ptr   <= '0;
         grant_id <= '0;
         grant_op <= OP_READ;
         pre_cnt  <= '0;
      end else begin
         if (state == ST_START) begin
            start_sr <= start_sr_shift;
         end
         if ((state == ST_IDLE) && arb_found) begin
            grant_id <= arb_id;
            grant_op <= arb_op;
         end
         if ((state == ST_ISSUE) && grant_valid) begin
            pre_cnt <= cnt_dout;
            rr_ptr  <= rr_ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_cnt_rr_sched.sv
// tb_cnt_rr_sched -- directed bench for cnt_rr_sched with a behavioural
// 74193-style counter wired to the strobes. Expected values are hand computed.
// Expectations follow CNT_RR_SCHED_SAT_EN when it is defined for the build.
module tb_cnt_rr_sched;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 4;

`ifdef CNT_RR_SCHED_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [2*NUM_REQ-1:0]      req_op;
   logic [WIDTH*NUM_REQ-1:0]  req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      cnt_load_en;
   logic                      cnt_inc_en;
   logic                      cnt_dec_en;
   logic [WIDTH-1:0]          cnt_din;
   logic [WIDTH-1:0]          cnt_dout = '0;
   logic                      rsp_valid;
   logic [1:0]                rsp_id;
   logic [WIDTH-1:0]          rsp_data;
   logic                      rsp_wrap;
   logic                      busy;

   int checks = 0;
   int errors = 0;

   logic [2:0] st;
   logic [3:0] din_seen;
   logic       v;
   logic [1:0] rid;
   logic [3:0] rdata;
   logic       wrap;

   cnt_rr_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .START_DLY(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_op      (req_op),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .cnt_load_en (cnt_load_en),
      .cnt_inc_en  (cnt_inc_en),
      .cnt_dec_en  (cnt_dec_en),
      .cnt_din     (cnt_din),
      .cnt_dout    (cnt_dout),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_wrap    (rsp_wrap),
      .busy        (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Behavioural counter: registered dout, load has priority, wraps modulo 16.
   always @(posedge clk) begin
      if (cnt_load_en)     cnt_dout <= cnt_din;
      else if (cnt_inc_en) cnt_dout <= cnt_dout + 4'd1;
      else if (cnt_dec_en) cnt_dout <= cnt_dout - 4'd1;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Post one command from requester id while the DUT is idle and capture both phases.
   task automatic applyStimulus(input int id, input logic [1:0] op, input logic [3:0] data,
                                output logic [2:0] strobes, output logic [3:0] din_s,
                                output logic rv, output logic [1:0] rid_s,
                                output logic [3:0] rdata_s, output logic rwrap_s);
      int n;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_op[2*id +: 2] = op;
      req_data[4*id +: 4] = data;
      n = 0;
      do begin
         step();
         n++;
      end while ((req_ready == '0) && (n < 20));
      checkOutput("grant", 32'(req_ready), 32'(4'b0001 << id));
      strobes = {cnt_load_en, cnt_inc_en, cnt_dec_en};
      din_s   = cnt_din;
      step();
      req_valid = '0;
      rv      = rsp_valid;
      rid_s   = rsp_id;
      rdata_s = rsp_data;
      rwrap_s = rsp_wrap;
      step();
   endtask

   initial begin
      $display("[TB] start, SAT=%0d", SAT);
      reset     = 1'b1;
      req_valid = '1;
      req_op    = {4{2'b01}};
      req_data  = '0;
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd1);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp", 32'({rsp_valid, rsp_wrap, rsp_data}), 32'd0);
      checkOutput("rst_strobe", 32'({cnt_load_en, cnt_inc_en, cnt_dec_en, cnt_din}), 32'd0);
      step();
      step();
      reset = 1'b0;

      // Start-up delay: three cycles of START with no grant.
      for (int k = 1; k <= 3; k++) begin
         step();
         checkOutput($sformatf("start_ready%0d", k), 32'(req_ready), 32'd0);
      end
      checkOutput("idle_busy", 32'(busy), 32'd0);

      // Continuous inc from all four: grants 0,1,2,3,0 with counts 1..5.
      for (int n = 0; n < 5; n++) begin
         step();
         checkOutput($sformatf("rr_ready%0d", n), 32'(req_ready), 32'(4'b0001 << (n % 4)));
         checkOutput($sformatf("rr_strobe%0d", n), 32'({cnt_load_en, cnt_inc_en, cnt_dec_en}), 32'b010);
         step();
         checkOutput($sformatf("rr_rsp%0d", n), 32'({rsp_valid, rsp_id, rsp_data, rsp_wrap}),
                     32'({1'b1, 2'(n % 4), 4'(n + 1), 1'b0}));
         step();
      end
      req_valid = '0;

      // Requester 2 loads F.
      applyStimulus(2, 2'b11, 4'hF, st, din_seen, v, rid, rdata, wrap);
      checkOutput("load_strobe", 32'({st, din_seen}), 32'({3'b100, 4'hF}));
      checkOutput("load_rsp", 32'({v, rid, rdata, wrap}), 32'({1'b1, 2'd2, 4'hF, 1'b0}));

      // Requester 1 incs at F: wraps to 0, or saturates.
      applyStimulus(1, 2'b01, 4'h0, st, din_seen, v, rid, rdata, wrap);
      checkOutput("incmax_strobe", 32'(st), SAT ? 32'b000 : 32'b010);
      checkOutput("incmax_rsp", 32'({v, rid, rdata, wrap}),
                  32'({1'b1, 2'd1, (SAT ? 4'hF : 4'h0), 1'b1}));

      // Requester 0 loads 0, then requester 3 decs at 0.
      applyStimulus(0, 2'b11, 4'h0, st, din_seen, v, rid, rdata, wrap);
      checkOutput("load0_rsp", 32'({v, rid, rdata, wrap}), 32'({1'b1, 2'd0, 4'h0, 1'b0}));
      applyStimulus(3, 2'b10, 4'h0, st, din_seen, v, rid, rdata, wrap);
      checkOutput("decmin_strobe", 32'(st), SAT ? 32'b000 : 32'b001);
      checkOutput("decmin_rsp", 32'({v, rid, rdata, wrap}),
                  32'({1'b1, 2'd3, (SAT ? 4'h0 : 4'hF), 1'b1}));

      // Load 7 then read: no strobe, no din, count 7.
      applyStimulus(0, 2'b11, 4'h7, st, din_seen, v, rid, rdata, wrap);
      checkOutput("load7_rsp", 32'({v, rid, rdata, wrap}), 32'({1'b1, 2'd0, 4'h7, 1'b0}));
      applyStimulus(0, 2'b00, 4'h9, st, din_seen, v, rid, rdata, wrap);
      checkOutput("read_strobe", 32'({st, din_seen}), 32'd0);
      checkOutput("read_rsp", 32'({v, rid, rdata, wrap}), 32'({1'b1, 2'd0, 4'h7, 1'b0}));

      // Ordinary dec away from the boundary.
      applyStimulus(2, 2'b10, 4'h0, st, din_seen, v, rid, rdata, wrap);
      checkOutput("dec_strobe", 32'(st), 32'b001);
      checkOutput("dec_rsp", 32'({v, rid, rdata, wrap}), 32'({1'b1, 2'd2, 4'h6, 1'b0}));

      // Valid dropped before ready: the command is not served.
      req_op[7:6] = 2'b01;
      req_valid = 4'b1000;
      step();
      req_valid = '0;
      #1;
      checkOutput("drop_ready", 32'({req_ready, cnt_load_en, cnt_inc_en, cnt_dec_en}), 32'd0);
      step();
      checkOutput("drop_idle", 32'({busy, rsp_valid}), 32'd0);
      checkOutput("drop_cnt", 32'(cnt_dout), 32'h6);

      // Reset during the ISSUE of a load from requester 1.
      req_op[3:2]   = 2'b11;
      req_data[7:4] = 4'hA;
      req_valid     = 4'b0010;
      step();
      checkOutput("pre_rst_issue", 32'({req_ready, cnt_load_en}), 32'({4'b0010, 1'b1}));
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_out", 32'({req_ready, cnt_load_en, cnt_inc_en, cnt_dec_en, cnt_din, rsp_valid}), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd1);
      step();
      checkOutput("mid_rst_rsp", 32'(rsp_valid), 32'd0);
      step();
      checkOutput("mid_rst_cnt", 32'(cnt_dout), 32'h6);
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         checkOutput($sformatf("restart_ready%0d", k), 32'({req_ready, rsp_valid}), 32'd0);
      end
      step();
      checkOutput("restart_issue", 32'({req_ready, cnt_load_en, cnt_din}), 32'({4'b0010, 1'b1, 4'hA}));
      step();
      req_valid = '0;
      checkOutput("restart_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_wrap}), 32'({1'b1, 2'd1, 4'hA, 1'b0}));
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cnt_rr_sched.md
Name: cnt_rr_sched

Overview:
- Round-robin scheduler that shares one 74193-style nibble counter (synchronous load_en/din/inc_en/dec_en, registered dout) between NUM_REQ requesters.
- Each requester posts one command (nop/read, inc, dec, load) with a valid/ready handshake.
- The block issues exactly one single-cycle control pulse to the counter, then returns the post-op count with a wrap flag.
- Sits between the request sources and a my_74193 instance in the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, counter data width; matches the counter din/dout width.
- START_DLY, 3, cycles after reset release before the first grant is allowed (synchronous enable shift register).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_op  in  2*NUM_REQ  per-requester op, slice i = [2i+1:2i]: 00 read, 01 inc, 10 dec, 11 load.
- req_data  in  WIDTH*NUM_REQ  per-requester load value, slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
- cnt_load_en  out  1  counter load strobe.
- cnt_inc_en  out  1  counter increment strobe.
- cnt_dec_en  out  1  counter decrement strobe.
- cnt_din  out  WIDTH  counter load value.
- cnt_dout  in  WIDTH  current counter value.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  log2(NUM_REQ)  index of the served requester.
- rsp_data  out  WIDTH  counter value after the op.
- rsp_wrap  out  1  op crossed the boundary: inc max->0 or dec 0->max.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, active-high):
  - All outputs 0; busy=1.
  - FSM=START; rr_ptr=0; start shift register cleared.
  - A reset mid-op abandons the op: no rsp_valid, no further strobe.
- States START -> IDLE -> ISSUE -> RESP -> IDLE.
- START:
  - Shift register shifts in 1 each cycle.
  - After START_DLY cycles go to IDLE. No grants in START.
- IDLE:
  - If any req_valid, select the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register the grant index and op; go to ISSUE. Otherwise stay.
- ISSUE (1 cycle):
  - req_ready[g]=1.
  - Exactly one strobe asserted per op: inc -> cnt_inc_en, dec -> cnt_dec_en, load -> cnt_load_en with cnt_din=req_data slice g. Read -> no strobe.
  - Capture pre-op cnt_dout.
  - rr_ptr <= (g+1) mod NUM_REQ.
- RESP (1 cycle):
  - rsp_valid=1, rsp_id=g, rsp_data=cnt_dout (post-op value).
  - rsp_wrap=1 iff (op=inc and pre=2^WIDTH-1) or (op=dec and pre=0). Load/read give 0.
- Strobes and req_ready are 0 outside ISSUE; at most one strobe is ever high.
- cnt_din is 0 except during a load ISSUE.
- Latency from grant to rsp_valid = 2 cycles; throughput 1 op per 3 cycles under continuous requests.
- Requesters hold req_op/req_data stable from valid until ready. Dropping valid before ready is allowed; the command is not served.
- req_valid deasserted after ISSUE is ignored; the captured op completes.

Optional Feature:
- Macro CNT_RR_SCHED_SAT_EN.
- Defined:
  - inc at 2^WIDTH-1 and dec at 0 are suppressed: no strobe, count unchanged.
  - rsp_wrap reports 1 for a suppressed op (saturation hit).
- Undefined: the counter wraps modulo 2^WIDTH and rsp_wrap flags the wrap.

Test Plan:
- Reset release with all req_valid=1 -> no req_ready for 3 cycles after START; first grant goes to requester 0.
- Requesters 0..3 all inc continuously from count 0 -> grants 0,1,2,3,0; rsp_data 1,2,3,4,5; rsp_id matches.
- Requester 2 loads 4'hF, then requester 1 incs -> rsp_data 0xF with wrap 0, then 0x0 with wrap 1. With SAT_EN the second response is 0xF with wrap 1 and no cnt_inc_en pulse.
- Count 0, requester 3 dec -> rsp_data 0xF, rsp_wrap=1. With SAT_EN: 0x0, wrap 1, no cnt_dec_en.
- Read op at count 7 -> no strobe; rsp_data=7, wrap 0.
- Assert reset during ISSUE of a load -> all outputs 0 immediately, no rsp_valid; START delay repeats before the next grant.
